// File: rtl/dma_priority_arbiter.sv
// Channel arbiter and HRQ/HLDA bus-request sequencer for the 4-channel DMA controller.
// Optional macro SW_REQ_EN adds the unmaskable software request port swReq.
module dma_priority_arbiter #(
    parameter int unsigned MIN_IDLE      = 1,
    parameter logic [7:0]  DEFAULT_ORDER = 8'b11_10_01_00
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic [3:0] maskReg,
    input  logic       ctrlDisable,
    input  logic       priorityType,
    input  logic       HLDA,
    input  logic       serviceDone,
`ifdef SW_REQ_EN
    input  logic [3:0] swReq,
`endif
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic       grantValid,
    output logic [1:0] grantChannel,
    output logic [7:0] priorityOrder
);

    typedef enum logic [1:0] {IDLE, REQ, GRANT} state_t;

    localparam logic [3:0] MIN_IDLE_C = 4'(MIN_IDLE);

    state_t     state_q, state_d;
    logic [3:0] idle_cnt_q, idle_cnt_d;
    logic       hrq_q, hrq_d;
    logic [3:0] dack_q, dack_d;
    logic       grant_valid_q, grant_valid_d;
    logic [1:0] grant_ch_q, grant_ch_d;
    logic [7:0] order_q, order_d;

    logic [3:0] raw_req, eff_req;
    logic       win_found;
    logic [1:0] win_ch;
    logic [7:0] rot_order;

    always_comb begin
`ifdef SW_REQ_EN
        raw_req = (DREQ & ~maskReg) | swReq;
`else
        raw_req = DREQ & ~maskReg;
`endif
        eff_req = ctrlDisable ? 4'b0000 : raw_req;
    end

    // Walk priority fields from [1:0] upward; the first requesting channel wins.
    always_comb begin
        win_found = 1'b0;
        win_ch    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!win_found && eff_req[order_q[2*i +: 2]]) begin
                win_found = 1'b1;
                win_ch    = order_q[2*i +: 2];
            end
        end
    end

    // Served channel drops to lowest priority, its successor becomes highest.
    always_comb begin
        rot_order = {grant_ch_q, 2'(grant_ch_q + 2'd3),
                     2'(grant_ch_q + 2'd2), 2'(grant_ch_q + 2'd1)};
    end

    always_comb begin
        state_d       = state_q;
        idle_cnt_d    = idle_cnt_q;
        hrq_d         = hrq_q;
        dack_d        = dack_q;
        grant_valid_d = grant_valid_q;
        grant_ch_d    = grant_ch_q;
        order_d       = order_q;
        case (state_q)
            IDLE: begin
                if (!priorityType) order_d = DEFAULT_ORDER;
                if (idle_cnt_q != 4'd0) begin
                    idle_cnt_d = idle_cnt_q - 4'd1;
                end else if (eff_req != 4'b0000) begin
                    hrq_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (eff_req == 4'b0000) begin
                    hrq_d      = 1'b0;
                    idle_cnt_d = MIN_IDLE_C;
                    state_d    = IDLE;
                end else if (HLDA && win_found) begin
                    dack_d        = 4'b0001 << win_ch;
                    grant_ch_d    = win_ch;
                    grant_valid_d = 1'b1;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (serviceDone || !HLDA) begin
                    dack_d        = 4'b0000;
                    grant_valid_d = 1'b0;
                    hrq_d         = 1'b0;
                    idle_cnt_d    = MIN_IDLE_C;
                    state_d       = IDLE;
                    if (serviceDone && priorityType) order_d = rot_order;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            idle_cnt_q    <= MIN_IDLE_C;
            hrq_q         <= 1'b0;
            dack_q        <= 4'b0000;
            grant_valid_q <= 1'b0;
            grant_ch_q    <= 2'd0;
            order_q       <= DEFAULT_ORDER;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            hrq_q         <= hrq_d;
            dack_q        <= dack_d;
            grant_valid_q <= grant_valid_d;
            grant_ch_q    <= grant_ch_d;
            order_q       <= order_d;
        end
    end

    assign HRQ           = hrq_q;
    assign DACK          = dack_q;
    assign grantValid    = grant_valid_q;
    assign grantChannel  = grant_ch_q;
    assign priorityOrder = order_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: fixed/rotating grants, masking, abort, reset, invariants.
module tb_dma_priority_arbiter;

    localparam int unsigned MIN_IDLE = 1;

    logic       CLK, RESET;
    logic [3:0] DREQ, maskReg;
    logic       ctrlDisable, priorityType, HLDA, serviceDone;
    logic [3:0] swReq;
    logic       HRQ, grantValid;
    logic [3:0] DACK;
    logic [1:0] grantChannel;
    logic [7:0] priorityOrder;

    int n_chk  = 0;
    int n_err  = 0;
    logic started = 1'b0;
    logic hlda_prev = 1'b0;
    int low_cnt = 0;

    logic [1:0] exp_ch  [5];
    logic [7:0] exp_ord [5];

    dma_priority_arbiter #(.MIN_IDLE(MIN_IDLE), .DEFAULT_ORDER(8'b11_10_01_00)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg),
        .ctrlDisable(ctrlDisable), .priorityType(priorityType), .HLDA(HLDA),
        .serviceDone(serviceDone),
`ifdef SW_REQ_EN
        .swReq(swReq),
`endif
        .HRQ(HRQ), .DACK(DACK), .grantValid(grantValid),
        .grantChannel(grantChannel), .priorityOrder(priorityOrder)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        DREQ = 4'b0000; HLDA = 1'b0; serviceDone = 1'b0; ctrlDisable = 1'b0;
        maskReg = 4'b0000; swReq = 4'b0000;
        repeat (4) cyc();
    endtask

    task automatic wait_grant(input int max);
        int n = 0;
        while (DACK == 4'b0000 && n < max) begin
            cyc();
            n++;
        end
        chk("grant_wait", {31'd0, DACK != 4'b0000}, 32'd1);
    endtask

    task automatic wait_hrq(input int max);
        int n = 0;
        while (!HRQ && n < max) begin
            cyc();
            n++;
        end
        chk("hrq_wait", {31'd0, HRQ}, 32'd1);
    endtask

    always @(posedge CLK) hlda_prev <= HLDA;

    // Invariants sampled on the falling edge.
    always @(negedge CLK) begin
        if (RESET) begin
            low_cnt = 0;
        end else if (started) begin
            chk("dack_onehot0", {31'd0, $onehot0(DACK)}, 32'd1);
            if (DACK != 4'b0000) begin
                chk("dack_needs_hrq", {31'd0, HRQ}, 32'd1);
                chk("dack_needs_hlda", {31'd0, hlda_prev}, 32'd1);
            end
            if (!HRQ) begin
                low_cnt++;
            end else begin
                if (low_cnt > 0) chk("min_idle", {31'd0, low_cnt >= int'(MIN_IDLE)}, 32'd1);
                low_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_ord = '{8'h39, 8'h4E, 8'h93, 8'hE4, 8'h39};
        RESET = 1'b0; DREQ = 4'b0000; maskReg = 4'b0000; ctrlDisable = 1'b0;
        priorityType = 1'b0; HLDA = 1'b0; serviceDone = 1'b0; swReq = 4'b0000;

        // 1. asynchronous reset values, no clock edge
        #3 RESET = 1'b1;
        #1;
        chk("rst_hrq", {31'd0, HRQ}, 32'd0);
        chk("rst_dack", {28'd0, DACK}, 32'd0);
        chk("rst_gv", {31'd0, grantValid}, 32'd0);
        chk("rst_gch", {30'd0, grantChannel}, 32'd0);
        chk("rst_order", {24'd0, priorityOrder}, 32'hE4);
        cyc();
        RESET = 1'b0;
        started = 1'b1;
        repeat (3) cyc();

        // 2. fixed priority, HLDA 3 cycles after HRQ
        DREQ = 4'b1010;
        cyc();
        chk("fix_hrq_rise", {31'd0, HRQ}, 32'd1);
        cyc();
        chk("fix_hrq_hold", {31'd0, HRQ}, 32'd1);
        chk("fix_no_dack", {28'd0, DACK}, 32'd0);
        cyc();
        HLDA = 1'b1;
        cyc();
        chk("fix_dack", {28'd0, DACK}, 32'h2);
        chk("fix_gch", {30'd0, grantChannel}, 32'd1);
        chk("fix_gv", {31'd0, grantValid}, 32'd1);
        serviceDone = 1'b1;
        cyc();
        serviceDone = 1'b0;
        chk("fix_done_dack", {28'd0, DACK}, 32'd0);
        chk("fix_done_hrq", {31'd0, HRQ}, 32'd0);
        chk("fix_done_gv", {31'd0, grantValid}, 32'd0);
        chk("fix_order", {24'd0, priorityOrder}, 32'hE4);
        cyc();
        chk("fix_idle_low", {31'd0, HRQ}, 32'd0);
        cyc();
        chk("fix_rerequest", {31'd0, HRQ}, 32'd1);
        settle();

        // 3. rotating priority
        priorityType = 1'b1; DREQ = 4'b1111; HLDA = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(8);
            chk($sformatf("rot_dack%0d", k), {28'd0, DACK}, {28'd0, 4'b0001 << exp_ch[k]});
            chk($sformatf("rot_gch%0d", k), {30'd0, grantChannel}, {30'd0, exp_ch[k]});
            serviceDone = 1'b1;
            cyc();
            serviceDone = 1'b0;
            chk($sformatf("rot_order%0d", k), {24'd0, priorityOrder}, {24'd0, exp_ord[k]});
            chk($sformatf("rot_rel%0d", k), {28'd0, DACK}, 32'd0);
        end
        priorityType = 1'b0;
        settle();
        chk("fixed_reload", {24'd0, priorityOrder}, 32'hE4);

        // 4. masking
        DREQ = 4'b0011; maskReg = 4'b0001; HLDA = 1'b1;
        wait_grant(8);
        chk("mask_dack", {28'd0, DACK}, 32'h2);
        settle();
        DREQ = 4'b0011; maskReg = 4'b0011; HLDA = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("mask_all_hrq", {31'd0, HRQ}, 32'd0);
        end
        settle();
        DREQ = 4'b0011;
        wait_hrq(8);
        DREQ = 4'b0000;
        cyc();
        chk("drop_hrq", {31'd0, HRQ}, 32'd0);
        chk("drop_dack", {28'd0, DACK}, 32'd0);
        settle();
        DREQ = 4'b0001;
        wait_hrq(8);
        ctrlDisable = 1'b1;
        cyc();
        chk("disable_hrq", {31'd0, HRQ}, 32'd0);
        cyc();
        chk("disable_idle", {31'd0, HRQ}, 32'd0);
        settle();

        // 5. abort, serviceDone racing HLDA loss, reset mid-grant
        priorityType = 1'b1; DREQ = 4'b0100; HLDA = 1'b1;
        wait_grant(8);
        chk("abort_dack_pre", {28'd0, DACK}, 32'h4);
        chk("abort_gch", {30'd0, grantChannel}, 32'd2);
        HLDA = 1'b0;
        cyc();
        chk("abort_dack", {28'd0, DACK}, 32'd0);
        chk("abort_hrq", {31'd0, HRQ}, 32'd0);
        chk("abort_order", {24'd0, priorityOrder}, 32'hE4);
        HLDA = 1'b1;
        wait_grant(8);
        serviceDone = 1'b1; HLDA = 1'b0;
        cyc();
        serviceDone = 1'b0;
        chk("race_dack", {28'd0, DACK}, 32'd0);
        chk("race_order", {24'd0, priorityOrder}, 32'h93);
        HLDA = 1'b1;
        wait_grant(8);
        chk("pre_rst_dack", {28'd0, DACK}, 32'h4);
        #2 RESET = 1'b1;
        #1;
        chk("midrst_dack", {28'd0, DACK}, 32'd0);
        chk("midrst_hrq", {31'd0, HRQ}, 32'd0);
        chk("midrst_gv", {31'd0, grantValid}, 32'd0);
        chk("midrst_order", {24'd0, priorityOrder}, 32'hE4);
        cyc();
        RESET = 1'b0;
        priorityType = 1'b0;
        settle();

`ifdef SW_REQ_EN
        // 6. software request ignores the mask
        swReq = 4'b0100; maskReg = 4'b1111; DREQ = 4'b0000;
        wait_hrq(8);
        HLDA = 1'b1;
        wait_grant(8);
        chk("sw_dack", {28'd0, DACK}, 32'h4);
        settle();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
Channel arbiter and bus-request sequencer for the 4-channel DMA controller. It does the following:
- Masks incoming DREQ lines.
- Raises HRQ to the CPU and waits for HLDA.
- Picks one channel by fixed or rotating priority and drives DACK for that channel until timing control reports the service is complete.
- Owns priorityOrder, which the datapath and status logic read.

Parameters:
MIN_IDLE, 1, minimum number of cycles HRQ stays low between two services (range 1..15).
DEFAULT_ORDER, 8'b11_10_01_00, priorityOrder value at reset and in fixed mode. Field [1:0] is the highest-priority channel.

Ports:
CLK  input  1  system clock.
RESET  input  1  asynchronous, active-high reset.
DREQ  input  4  channel DMA requests, active high.
maskReg  input  4  per-channel mask; 1 blocks that channel.
ctrlDisable  input  1  commandReg controller-disable bit; 1 blocks all new arbitration.
priorityType  input  1  0 selects fixed priority, 1 selects rotating priority.
HLDA  input  1  hold acknowledge from the CPU.
serviceDone  input  1  one-cycle pulse from timing control marking the end of the current service.
HRQ  output  1  hold request to the CPU.
DACK  output  4  one-hot DMA acknowledge.
grantValid  output  1  high while DACK is non-zero.
grantChannel  output  2  encoded number of the granted channel.
priorityOrder  output  8  current priority order, four 2-bit channel fields.

Behaviour:
- Reset:
  - Asynchronous and active-high; state returns to IDLE immediately.
  - HRQ=0, DACK=4'b0000, grantValid=0, grantChannel=0, priorityOrder=DEFAULT_ORDER, idle counter=MIN_IDLE.
- effReq = DREQ & ~maskReg, and is forced to 0 when ctrlDisable=1. All outputs are registered.
- State IDLE:
  - The idle counter decrements to 0.
  - If effReq!=0 and the counter is 0: HRQ=1 on the next edge and the state goes to REQ.
- State REQ:
  - HRQ held at 1.
  - If HLDA=1: the winner is the first channel in priorityOrder (field [1:0] first) whose effReq bit is set, sampled in this cycle. On the next edge DACK=onehot(winner), grantChannel=winner, grantValid=1, and the state goes to GRANT.
  - If HLDA=0 and effReq==0: on the next edge HRQ=0, the state goes to IDLE, and the counter reloads MIN_IDLE.
  - If HLDA=1 and effReq==0 in the same cycle: HRQ=0 and the state goes to IDLE (no grant).
- State GRANT:
  - DACK and grantChannel are frozen.
  - A DREQ drop or mask change on the granted channel does not end the grant; only serviceDone or the loss of HLDA does.
  - On serviceDone=1, at the next edge:
    - DACK=0, grantValid=0, HRQ=0;
    - the state goes to IDLE and the counter reloads MIN_IDLE;
    - if priorityType=1, priorityOrder rotates so the served channel c becomes lowest: the order is {c, c+3, c+2, c+1} mod 4, with field [1:0]=c+1.
  - If HLDA falls (abort):
    - at the next edge DACK=0, grantValid=0, HRQ=0, and the state goes to IDLE;
    - no rotation takes place.
  - If serviceDone and an HLDA fall happen in the same cycle, serviceDone wins and rotation applies.
- Invariants, checked by the bench:
  - DACK is always one-hot or zero.
  - DACK!=0 implies HRQ=1 and HLDA was 1 in the previous cycle.
  - HRQ stays low for at least MIN_IDLE cycles after every release.
- Fixed mode:
  - When priorityType=0, priorityOrder is reloaded with DEFAULT_ORDER on the next edge, but only while the state is IDLE.
  - A change to priorityType while in REQ or GRANT takes effect at the next IDLE.
- ctrlDisable=1:
  - In REQ, it is treated as effReq==0.
  - In GRANT, the service completes normally.

Optional Feature:
SW_REQ_EN
- Defined: adds port swReq (input, 4 bits), the software request register. Requests become effReq = ((DREQ & ~maskReg) | swReq), gated by ctrlDisable. Software requests are not maskable.
- Not defined: the port is absent and effReq = DREQ & ~maskReg, gated by ctrlDisable.

Test Plan:
1. Reset-value check:
   - Stimulus: assert RESET between clock edges.
   - Required response: HRQ=0, DACK=0000 and priorityOrder=8'b11100100 without waiting for a clock edge.
2. Fixed-priority grant:
   - Stimulus: priorityType=0, maskReg=0000, DREQ=1010, HLDA raised 3 cycles after HRQ.
   - Required response: HRQ=1 one cycle after DREQ; DACK=0010 one cycle after HLDA; serviceDone produces DACK=0000, HRQ=0 next cycle, and HRQ stays low ≥MIN_IDLE cycles.
3. Rotating-priority sequence:
   - Stimulus: priorityType=1, DREQ=1111 held, HLDA held high, serviceDone pulsed in each GRANT.
   - Required response: grants go to channels 0, 1, 2, 3, 0 in that order, and after the first service priorityOrder=8'b00_11_10_01.
4. Masking:
   - Stimulus: DREQ=0011, maskReg=0001.
   - Required response: DACK=0010.
   - Stimulus: maskReg=0011.
   - Required response: HRQ never rises.
   - Stimulus: drop DREQ to 0000 while in REQ.
   - Required response: HRQ=0 next cycle with no DACK.
5. Abort on HLDA loss:
   - Stimulus: deassert HLDA while in GRANT on channel 2.
   - Required response: DACK=0000 and HRQ=0 next cycle; priorityOrder unchanged.
   - Stimulus: RESET mid-grant.
   - Required response: immediate return to the reset values.
6. SW_REQ_EN build:
   - Stimulus: swReq=0100, maskReg=1111, DREQ=0000.
   - Required response: HRQ=1, then DACK=0100 after HLDA.
